// File: rtl/imem_if.sv
// imem_if: fetch-side bus between a fetch initiator and imem_responder.
//   req_valid/req_ready/req_addr : word-fetch request channel
//   rsp_valid/rsp_ready/rsp_data/rsp_fault : response channel
//   wr_en/wr_addr/wr_data        : side write port used to fill the memory
// master = fetch initiator / loader, slave = responder.
interface imem_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic [1:0]      rsp_fault;
  logic            wr_en;
  logic [XLEN-1:0] wr_addr;
  logic [XLEN-1:0] wr_data;

  modport master (
    output req_valid, req_addr, rsp_ready, wr_en, wr_addr, wr_data,
    input  req_ready, rsp_valid, rsp_data, rsp_fault
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, wr_en, wr_addr, wr_data,
    output req_ready, rsp_valid, rsp_data, rsp_fault
  );
endinterface

// File: rtl/imem_responder.sv
// imem_responder: instruction memory answering word fetches after a fixed
// number of wait states, with a side write port for filling the array.
// Ports:
//   clk_i     : clock
//   reset_n_i : synchronous active-low reset
//   bus       : imem_if.slave (request, response and write channels)
// Response fault codes: 00 ok, 01 misaligned, 10 out of range.
// A faulted request returns data 0 with the same latency as a good one.
module imem_responder #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned     DEPTH_WORDS = 1024,
  parameter int unsigned     WAIT_STATES = 2
) (
  input logic   clk_i,
  input logic   reset_n_i,
  imem_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  // One past the last valid byte address, one bit wider so it cannot wrap.
  localparam logic [XLEN:0] END_ADDR = {1'b0, BASE_ADDR} + (XLEN+1)'(4 * DEPTH_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] F_OK    = 2'b00;
  localparam logic [1:0] F_ALIGN = 2'b01;
  localparam logic [1:0] F_RANGE = 2'b10;

  // Misalignment wins over out-of-range.
  function automatic logic [1:0] addr_fault(input logic [XLEN-1:0] a);
    if (a[1:0] != 2'b00)                          return F_ALIGN;
    if (a < BASE_ADDR || {1'b0, a} >= END_ADDR)   return F_RANGE;
    return F_OK;
  endfunction

  // Offset wraps modulo 2^XLEN; only meaningful once addr_fault() is clean.
  function automatic logic [IDX_W-1:0] addr_idx(input logic [XLEN-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  logic [XLEN-1:0]  mem_q [DEPTH_WORDS];

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       fault_q, fault_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]  rsp_data_q, rsp_data_d;
  logic [1:0]       rsp_fault_q, rsp_fault_d;

  // The counter is loaded with WAIT_STATES and runs down to zero; the edge
  // taken at zero is the array-read edge that enters RESP. That puts the
  // response WAIT_STATES+1 edges after acceptance, and WAIT_STATES=0 still
  // reads from the latched index rather than the live request address.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    fault_d     = fault_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_fault_d = rsp_fault_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          state_d = S_WAIT;
          cnt_d   = 4'(WAIT_STATES);
          idx_d   = addr_idx(bus.req_addr);
          fault_d = addr_fault(bus.req_addr);
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_fault_d = fault_q;
          // Faulted requests never touch the array.
          rsp_data_d  = (fault_q == F_OK) ? mem_q[idx_q] : '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      fault_q     <= F_OK;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_fault_q <= F_OK;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      fault_q     <= fault_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  // Array has no reset. A write on the RESP-entry edge lands after the read
  // above samples mem_q, so that response carries the old word.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && bus.wr_en && addr_fault(bus.wr_addr) == F_OK)
      mem_q[addr_idx(bus.wr_addr)] <= bus.wr_data;
  end

  assign bus.req_ready = reset_n_i && (state_q == S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_fault = rsp_fault_q;

endmodule
